pipe_hazard_ctrl: RTL

Central pipeline sequencer for the 5-stage semiMIPS core. Resolves branches and jumps arriving from the EX/MEM register, detects load-use hazards between ID/EX and IF/ID, and freezes the pipeline while data memory has not acknowledged a request. It drives PC select, PC/IF-ID write enables, the flush pins of the IF/ID, ID/EX and EX/MEM registers, and the global pipeline enable. It also halts the core on program finish or memory timeout and keeps saturating stall/flush event counters.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/sequencing controller for the 5-stage semiMIPS pipeline:
// branch/jump redirect, load-use bubbles, data-memory wait freeze, halt and event counters.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CWIDTH      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exmem_bbeq,
   input  logic              exmem_bbne,
   input  logic              exmem_bblez,
   input  logic              exmem_bbgtz,
   input  logic              exmem_jump,
   input  logic              exmem_zero,
   input  logic              exmem_negative,
   input  logic              exmem_memrd,
   input  logic              exmem_memwr,
   input  logic              dmem_ack,
   input  logic              idex_memrd,
   input  logic [4:0]        idex_rt,
   input  logic [4:0]        ifid_rs,
   input  logic [4:0]        ifid_rt,
   input  logic              memwb_fin,
   output logic [1:0]        pcsrc,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic              pipe_en,
   output logic              dmem_req,
   output logic              halted,
   output logic              mem_err,
   output logic [CWIDTH-1:0] stall_cnt,
   output logic [CWIDTH-1:0] flush_cnt
);

   localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, HALT = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic              mem_err_q, mem_err_d;
   logic [CWIDTH-1:0] stall_q, stall_d;
   logic [CWIDTH-1:0] flush_q, flush_d;

   logic taken, redirect, ldhaz, req, memwait, timeout;

   function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
      return (&v) ? v : v + CWIDTH'(1);
   endfunction

   always_comb begin
      taken    = (exmem_bbeq  &  exmem_zero)
               | (exmem_bbne  & ~exmem_zero)
               | (exmem_bblez & (exmem_zero | exmem_negative))
               | (exmem_bbgtz & ~exmem_zero & ~exmem_negative);
      redirect = taken | exmem_jump;
      ldhaz    = idex_memrd & (idex_rt != 5'd0) &
                 ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
      req      = (exmem_memrd | exmem_memwr) & (state_q != HALT);
      memwait  = req & ~dmem_ack;
      // This cycle is the MEM_TIMEOUT-th consecutive unacknowledged one.
      timeout  = memwait & (wait_q >= WW'(MEM_TIMEOUT - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      case (state_q)
         HALT: begin
            state_d = HALT;
         end
         default: begin
            if (memwait) begin
               if (timeout) begin
                  state_d   = HALT;
                  wait_d    = '0;
                  mem_err_d = 1'b1;
               end else begin
                  state_d = MEMWAIT;
                  wait_d  = wait_q + WW'(1);
               end
            end else begin
               wait_d  = '0;
               state_d = memwb_fin ? HALT : RUN;
            end
         end
      endcase
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (state_q != HALT) begin
         if (memwait)
            stall_d = sat_inc(stall_q);
         else if (redirect)
            flush_d = sat_inc(flush_q);
         else if (ldhaz)
            stall_d = sat_inc(stall_q);
      end
   end

   always_comb begin
      pcsrc       = 2'b00;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pipe_en     = 1'b1;
      halted      = 1'b0;
      if (state_q == HALT) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_en    = 1'b0;
         halted     = 1'b1;
      end else if (memwait) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_en    = 1'b0;
      end else if (redirect) begin
         // Younger instructions are squashed, so a coincident load-use hazard is moot.
         pcsrc       = taken ? 2'b01 : 2'b10;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (ldhaz) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   assign dmem_req  = req;
   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule
